complex_addsub_pipe: RTL and testbench
======================================

# complex_addsub_pipe

Parametrised, pipelined complex adder/subtractor for the FFT datapath, and the successor to the combinational `complex_sub`. Operands are packed complex words: real part in the upper half, imaginary part in the lower half, both two's complement. Per beat, the block adds or subtracts, then either saturates or scales by ½ (FFT per-stage block scaling). It runs behind a valid/ready handshake so it can sit between the butterfly stage buffers.

## Interface
Parameters:
- `W`, default 8: component width in bits; packed word is 2W bits.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_valid`, input, 1: the input beat is valid.
- `o_in_ready`, output, 1: the block accepts a beat this cycle.
- `i_A`, input, 2W: operand A, `{real, imag}`.
- `i_B`, input, 2W: operand B, `{real, imag}`.
- `i_sub`, input, 1: 0 gives A+B; 1 gives A−B. Sampled with the beat.
- `i_scale`, input, 1: 1 applies an arithmetic shift right by 1 to the result; 0 saturates it. Sampled with the beat.
- `i_clr_sat`, input, 1: clears `o_sat_sticky`.
- `o_valid`, output, 1: the output beat is valid.
- `i_ready`, input, 1: the downstream stage accepts the output beat.
- `o_result`, output, 2W: result, `{real, imag}`.
- `o_sat`, output, 1: at least one component of this output beat saturated.
- `o_sat_sticky`, output, 1: a saturation has occurred since the last clear or reset.

## Operation
- A beat transfers in when `i_valid && o_in_ready`. It transfers out when `o_valid && i_ready`.
- Each component is sign-extended to W+1 bits. Raw result r = a ± b, which is exact in W+1 bits.
- Scale mode (`i_scale`=1):
  - result = r >>> 1, taking the low W bits; this floors toward −∞.
  - It never saturates, so `o_sat`=0.
- Saturate mode (`i_scale`=0):
  - If r > 2^(W−1)−1, the result is 2^(W−1)−1.
  - If r < −2^(W−1), the result is −2^(W−1).
  - Otherwise the result is r[W−1:0].
- `o_sat` is the OR of the real and imaginary saturation events for that beat.
- `o_sat_sticky` sets in the cycle an output beat with `o_sat`=1 transfers out.
  - `i_clr_sat` clears it.
  - If set and clear happen in the same cycle, set wins.
- The mode bits travel with their beat. Mixing modes beat-to-beat is legal and has no bubbles.

## Timing
- The pipeline has two register stages:
  - S1 holds the registered raw W+1-bit sums plus the mode bits.
  - S2 holds the scaled or saturated result plus `o_sat`.
- Latency is 2 cycles from input transfer to `o_valid` when `i_ready` is held at 1. Throughput is 1 beat per cycle.
- Stall rules:
  - S2 loads when S2 is empty or `i_ready`=1.
  - S1 loads when S1 is empty or S1 is moving to S2.
  - `o_in_ready` = !S1_valid || S2 can load. This path is combinational from `i_ready`.
- Under backpressure, at most 2 beats are held. Nothing is dropped or duplicated, and order is preserved.
- Outputs are stable while `o_valid && !i_ready`.
- Reset values:
  - `o_valid`=0, `o_result`=0, `o_sat`=0, `o_sat_sticky`=0.
  - Both stage valid flags are 0.
  - `o_in_ready` is 1 one cycle after release.
- Reset asserted mid-operation discards all in-flight beats immediately.
- Data registers must not change while their stage is held.

## Structure
- Shared package `complex_pkg`:
  - default `W`;
  - real/imag extract functions for a 2W-bit word;
  - a W+1-to-W saturate function;
  - an arithmetic-shift scale function.
- Sub-module `cplx_lane_addsub`: one combinational component lane (sign-extend, add/sub, scale/saturate, sat flag), instantiated twice. The registers and handshake stay in the top level.

## Test plan
- Sub, W=8: A=0x0421 (4, 33), B=0x0224 (2, 36), `i_sub`=1, `i_scale`=0.
  - `o_result`=0x02FD and `o_sat`=0, two cycles later.
- Sub with negatives: A=0xFFFE (−1, −2), B=0xFE05 (−2, 5), `i_sub`=1.
  - `o_result`=0x01F9 and `o_sat`=0.
- Saturation: A=0x7F80 (127, −128), B=0x0101 (1, 1), add, `i_scale`=0.
  - `o_result`=0x7F81 and `o_sat`=1.
  - `o_sat_sticky`=1 afterwards.
  - After a cycle with `i_clr_sat`=1, `o_sat_sticky`=0.
- Scaling: A=0x7F7F (127, 127), B=0x7F80 (127, −128), add, `i_scale`=1.
  - `o_result`=0x7FFF (127, −1) and `o_sat`=0.
- Backpressure: stream 4 beats with `i_ready`=0 for 3 cycles.
  - `o_in_ready` drops after 2 beats are held.
  - After release, all 4 results emerge in order, unchanged, at 1 per cycle.
- Reset mid-stream: assert `i_rst_n`=0 with 2 beats in flight.
  - `o_valid`=0 immediately.
  - No stale beat emerges after release.
  - `o_sat_sticky`=0.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared helpers for the packed complex datapath: component extraction,
// saturation and scale-by-half on a sign-extended raw sum.
package complex_pkg;

    localparam int W_DEFAULT = 8;
    localparam int MAX_W     = 32;

    typedef logic signed [MAX_W:0] wide_t;

    function automatic logic [MAX_W-1:0] comp_mask(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] real_part(input logic [2*MAX_W-1:0] word, input int w);
        return MAX_W'(word >> w) & comp_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] imag_part(input logic [2*MAX_W-1:0] word, input int w);
        return MAX_W'(word) & comp_mask(w);
    endfunction

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    function automatic logic is_sat(input wide_t r, input int w);
        return (r > sat_max(w)) || (r < sat_min(w));
    endfunction

    function automatic logic [MAX_W-1:0] saturate(input wide_t r, input int w);
        if (r > sat_max(w)) begin
            return MAX_W'(sat_max(w));
        end else if (r < sat_min(w)) begin
            return MAX_W'(sat_min(w));
        end
        return MAX_W'(r);
    endfunction

    // Arithmetic shift floors toward minus infinity.
    function automatic logic [MAX_W-1:0] scale_half(input wide_t r);
        return MAX_W'(r >>> 1);
    endfunction

endpackage

// File: rtl/cplx_lane_addsub.sv
// One component lane: the add/sub half feeds stage 1, the scale/saturate
// half consumes the registered raw sum and feeds stage 2.
module cplx_lane_addsub
    import complex_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W:0]   raw_o,
    input  logic [W:0]   raw_i,
    input  logic         scale_i,
    output logic [W-1:0] res_o,
    output logic         sat_o
);

    logic [W:0] a_ext;
    logic [W:0] b_ext;
    wide_t      raw_wide;

    assign a_ext = {a_i[W-1], a_i};
    assign b_ext = {b_i[W-1], b_i};
    assign raw_o = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

    assign raw_wide = {{(MAX_W - W){raw_i[W]}}, raw_i};
    assign res_o    = scale_i ? W'(scale_half(raw_wide)) : W'(saturate(raw_wide, W));
    assign sat_o    = !scale_i && is_sat(raw_wide, W);

endmodule

// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex add/sub with per-beat saturate or scale-by-half,
// behind a valid/ready handshake with a sticky saturation flag.
module complex_addsub_pipe
    import complex_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_valid,
    output logic           o_in_ready,
    input  logic [2*W-1:0] i_A,
    input  logic [2*W-1:0] i_B,
    input  logic           i_sub,
    input  logic           i_scale,
    input  logic           i_clr_sat,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [2*W-1:0] o_result,
    output logic           o_sat,
    output logic           o_sat_sticky
);

    logic           s1_valid_q, s1_valid_d;
    logic [W:0]     s1_re_q, s1_re_d;
    logic [W:0]     s1_im_q, s1_im_d;
    logic           s1_scale_q;
    logic           s2_valid_q, s2_valid_d;
    logic [2*W-1:0] s2_result_q;
    logic           s2_sat_q;
    logic           sticky_q, sticky_d;

    logic           s1_load, s2_load, in_fire, out_fire;
    logic [W-1:0]   a_re, a_im, b_re, b_im;
    logic [W-1:0]   res_re, res_im;
    logic           sat_re, sat_im;

    assign a_re = W'(real_part({{(2*MAX_W - 2*W){1'b0}}, i_A}, W));
    assign a_im = W'(imag_part({{(2*MAX_W - 2*W){1'b0}}, i_A}, W));
    assign b_re = W'(real_part({{(2*MAX_W - 2*W){1'b0}}, i_B}, W));
    assign b_im = W'(imag_part({{(2*MAX_W - 2*W){1'b0}}, i_B}, W));

    cplx_lane_addsub #(.W(W)) u_lane_re (
        .a_i     (a_re),
        .b_i     (b_re),
        .sub_i   (i_sub),
        .raw_o   (s1_re_d),
        .raw_i   (s1_re_q),
        .scale_i (s1_scale_q),
        .res_o   (res_re),
        .sat_o   (sat_re)
    );

    cplx_lane_addsub #(.W(W)) u_lane_im (
        .a_i     (a_im),
        .b_i     (b_im),
        .sub_i   (i_sub),
        .raw_o   (s1_im_d),
        .raw_i   (s1_im_q),
        .scale_i (s1_scale_q),
        .res_o   (res_im),
        .sat_o   (sat_im)
    );

    // S1 can refill in the same cycle it drains into S2, giving full throughput.
    always_comb begin
        s2_load    = !s2_valid_q || i_ready;
        s1_load    = !s1_valid_q || s2_load;
        in_fire    = i_valid && s1_load;
        out_fire   = s2_valid_q && i_ready;
        s1_valid_d = s1_load ? in_fire : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        sticky_d   = sticky_q;
        if (out_fire && s2_sat_q) begin
            sticky_d = 1'b1;
        end else if (i_clr_sat) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_scale_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_sat_q    <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sticky_q   <= sticky_d;
            if (in_fire) begin
                s1_re_q    <= s1_re_d;
                s1_im_q    <= s1_im_d;
                s1_scale_q <= i_scale;
            end
            if (s2_load && s1_valid_q) begin
                s2_result_q <= {res_re, res_im};
                s2_sat_q    <= sat_re || sat_im;
            end
        end
    end

    assign o_in_ready   = s1_load;
    assign o_valid      = s2_valid_q;
    assign o_result     = s2_result_q;
    assign o_sat        = s2_sat_q;
    assign o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Directed-vector bench for complex_addsub_pipe with hand-computed results.
module tb_complex_addsub_pipe;

    localparam int W = 8;

    logic           i_clk;
    logic           i_rst_n;
    logic           i_valid;
    logic           o_in_ready;
    logic [2*W-1:0] i_A;
    logic [2*W-1:0] i_B;
    logic           i_sub;
    logic           i_scale;
    logic           i_clr_sat;
    logic           o_valid;
    logic           i_ready;
    logic [2*W-1:0] o_result;
    logic           o_sat;
    logic           o_sat_sticky;

    int checks   = 0;
    int failures = 0;

    complex_addsub_pipe #(.W(W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_sub        (i_sub),
        .i_scale      (i_scale),
        .i_clr_sat    (i_clr_sat),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_sat        (o_sat),
        .o_sat_sticky (o_sat_sticky)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic setBeat(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic scale);
        i_A     = a;
        i_B     = b;
        i_sub   = sub;
        i_scale = scale;
    endtask

    task automatic driveBeat(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic scale);
        setBeat(a, b, sub, scale);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic waitOut(output int cycles);
        cycles = 1;
        while (!o_valid && cycles < 8) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr_sat = 1'b0;
        setBeat(16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_result !== 16'h0000) begin failures++; $display("[TB] FAIL rst_result: got %h expected 0000", o_result); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("[TB] FAIL rst_sat: got %b expected 0", o_sat); end
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL rst_sticky: got %b expected 0", o_sat_sticky); end
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_inready: got %b expected 1", o_in_ready); end
    endtask

    task automatic test_sub();
        int cyc;
        driveBeat(16'h0421, 16'h0224, 1'b1, 1'b0);
        waitOut(cyc);
        checks++; if (o_valid !== 1'b1 || cyc != 2) begin failures++; $display("[TB] FAIL sub_latency: got valid=%b after %0d cycles expected valid=1 after 2", o_valid, cyc); end
        checks++; if (o_result !== 16'h02FD) begin failures++; $display("[TB] FAIL sub_result: got %h expected 02fd", o_result); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("[TB] FAIL sub_sat: got %b expected 0", o_sat); end
        tick();
        driveBeat(16'hFFFE, 16'hFE05, 1'b1, 1'b0);
        waitOut(cyc);
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h01F9) begin failures++; $display("[TB] FAIL subneg_result: got valid=%b %h expected 01f9", o_valid, o_result); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("[TB] FAIL subneg_sat: got %b expected 0", o_sat); end
        tick();
    endtask

    task automatic test_saturation();
        int cyc;
        driveBeat(16'h7F80, 16'h0101, 1'b0, 1'b0);
        waitOut(cyc);
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h7F81) begin failures++; $display("[TB] FAIL sat_result: got valid=%b %h expected 7f81", o_valid, o_result); end
        checks++; if (o_sat !== 1'b1) begin failures++; $display("[TB] FAIL sat_flag: got %b expected 1", o_sat); end
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL sat_sticky_early: got %b expected 0", o_sat_sticky); end
        tick();
        checks++; if (o_sat_sticky !== 1'b1) begin failures++; $display("[TB] FAIL sat_sticky_set: got %b expected 1", o_sat_sticky); end
        i_clr_sat = 1'b1;
        tick();
        i_clr_sat = 1'b0;
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL sat_sticky_clr: got %b expected 0", o_sat_sticky); end
    endtask

    task automatic test_scale();
        int cyc;
        driveBeat(16'h7F7F, 16'h7F80, 1'b0, 1'b1);
        waitOut(cyc);
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h7FFF) begin failures++; $display("[TB] FAIL scale_result: got valid=%b %h expected 7fff", o_valid, o_result); end
        checks++; if (o_sat !== 1'b0) begin failures++; $display("[TB] FAIL scale_sat: got %b expected 0", o_sat); end
        tick();
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL scale_sticky: got %b expected 0", o_sat_sticky); end
    endtask

    task automatic test_back_to_back();
        setBeat(16'h7F7F, 16'h0101, 1'b0, 1'b0);
        i_valid = 1'b1;
        tick();
        setBeat(16'hFD03, 16'h0000, 1'b0, 1'b1);
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_result !== 16'h7F7F || o_sat !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first: got valid=%b %h sat=%b expected 1 7f7f 1", o_valid, o_result, o_sat); end
        i_clr_sat = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b1 || o_result !== 16'hFE01 || o_sat !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second: got valid=%b %h sat=%b expected 1 fe01 0", o_valid, o_result, o_sat); end
        checks++; if (o_sat_sticky !== 1'b1) begin failures++; $display("[TB] FAIL b2b_set_wins: got %b expected 1", o_sat_sticky); end
        tick();
        i_clr_sat = 1'b0;
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL b2b_sticky_clr: got %b expected 0", o_sat_sticky); end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [4] = '{16'h0102, 16'h1010, 16'h4040, 16'h8080};
        logic [15:0] vb [4] = '{16'h0304, 16'h0101, 16'h4040, 16'h0101};
        logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] er [4] = '{16'h0406, 16'h0F0F, 16'h4040, 16'h8080};
        logic        es [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int inIdx, outIdx, firstOut, lastOut;
        logic fire;
        i_ready = 1'b0;
        setBeat(va[0], vb[0], vs[0], vc[0]);
        i_valid = 1'b1;
        tick();
        setBeat(va[1], vb[1], vs[1], vc[1]);
        tick();
        setBeat(va[2], vb[2], vs[2], vc[2]);
        checks++; if (o_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_inready_drop: got %b expected 0", o_in_ready); end
        checks++; if (o_valid !== 1'b1 || o_result !== er[0]) begin failures++; $display("[TB] FAIL bp_head: got valid=%b %h expected 1 %h", o_valid, o_result, er[0]); end
        tick();
        tick();
        checks++; if (o_valid !== 1'b1 || o_result !== er[0] || o_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold: got valid=%b %h inready=%b expected 1 %h 0", o_valid, o_result, o_in_ready, er[0]); end
        i_ready = 1'b1;
        #1;
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_inready_release: got %b expected 1", o_in_ready); end
        inIdx = 2; outIdx = 0; firstOut = -1; lastOut = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (o_valid) begin
                if (outIdx < 4) begin
                    checks++;
                    if (o_result !== er[outIdx] || o_sat !== es[outIdx]) begin
                        failures++;
                        $display("[TB] FAIL bp_beat%0d: got %h sat=%b expected %h sat=%b", outIdx, o_result, o_sat, er[outIdx], es[outIdx]);
                    end
                end
                if (firstOut < 0) firstOut = cyc;
                lastOut = cyc;
                outIdx++;
            end
            if (inIdx < 4) begin
                setBeat(va[inIdx], vb[inIdx], vs[inIdx], vc[inIdx]);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            fire = i_valid && o_in_ready;
            tick();
            if (fire) inIdx++;
        end
        i_valid = 1'b0;
        checks++; if (outIdx != 4) begin failures++; $display("[TB] FAIL bp_count: got %0d beats expected 4", outIdx); end
        checks++; if (lastOut - firstOut != 3) begin failures++; $display("[TB] FAIL bp_throughput: got span %0d expected 3", lastOut - firstOut); end
        i_clr_sat = 1'b1;
        tick();
        i_clr_sat = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic stale;
        i_ready = 1'b1;
        setBeat(16'h7F80, 16'h0101, 1'b0, 1'b0);
        i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_inflight: got %b expected 1", o_valid); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid_drop: got %b expected 0", o_valid); end
        tick();
        i_rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            stale |= o_valid;
        end
        checks++; if (stale !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale: got stale beat=%b expected 0", stale); end
        checks++; if (o_sat_sticky !== 1'b0) begin failures++; $display("[TB] FAIL mid_sticky: got %b expected 0", o_sat_sticky); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_saturation();
        test_scale();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
